// File: rtl/q2q3_skid.sv
// q2q3_skid: elastic ID/EX pipeline register.
// Two-entry skid buffer between decode (q2) and execute (q3).
// Handshake: a bundle moves across an interface in any cycle where its
// valid and ready are both 1 at the rising clock edge. valid_o holds, and
// the payload stays constant, until execute takes the bundle. ready_o is
// decoded from registered state only, so it never depends on this
// cycle's ready_i or valid_i.
module q2q3_skid #(
    parameter int          CTRL_WIDTH = 16,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [31:0]           pc_incr_i,
    input  logic [31:0]           reg_rd_data1_i,
    input  logic [31:0]           reg_rd_data2_i,
    input  logic [4:0]            reg_wr_port_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_q2_i,
    input  logic [31:0]           instr_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [31:0]           pc_incr_o,
    output logic [31:0]           reg_rd_data1_o,
    output logic [31:0]           reg_rd_data2_o,
    output logic [4:0]            reg_wr_port_o,
    output logic [CTRL_WIDTH-1:0] ctrl_q2_o,
    output logic [31:0]           instr_o,
    output logic [1:0]            occupancy_o
);

    typedef struct packed {
        logic [31:0]           pc_incr;
        logic [31:0]           rd_data1;
        logic [31:0]           rd_data2;
        logic [4:0]            wr_port;
        logic [CTRL_WIDTH-1:0] ctrl;
        logic [31:0]           instr;
    } bundle_t;

    // The encoding equals the occupancy count, so occupancy_o doubles as
    // a direct view of the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t  state_q;
    bundle_t main_q;
    bundle_t skid_q;
    bundle_t in_bundle;
    bundle_t bubble;

    assign in_bundle = {pc_incr_i, reg_rd_data1_i, reg_rd_data2_i,
                        reg_wr_port_i, ctrl_q2_i, instr_i};

    // Bubble contents: a NOP with an all-zero control word.
    always_comb begin
        bubble       = '0;
        bubble.instr = NOP_INSTR;
    end

    // FSM and storage: reset beats flush, and flush beats every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= bubble;
            skid_q  <= '0;
        end else if (flush_i) begin
            state_q <= ST_EMPTY;
            main_q  <= bubble;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (valid_i) begin
                        main_q  <= in_bundle;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (valid_i && ready_i) begin
                        main_q <= in_bundle;
                    end else if (valid_i) begin
                        skid_q  <= in_bundle;
                        state_q <= ST_SKID;
                    end else if (ready_i) begin
                        main_q  <= bubble;
                        state_q <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // ready_o is 0 here, so valid_i is ignored.
                    if (ready_i) begin
                        main_q  <= skid_q;
                        state_q <= ST_FULL;
                    end
                end
                default: begin
                    main_q  <= bubble;
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake and occupancy outputs, decoded from the state register only.
    always_comb begin
        valid_o     = 1'b0;
        ready_o     = 1'b1;
        occupancy_o = 2'd0;
        case (state_q)
            ST_FULL: begin
                valid_o     = 1'b1;
                ready_o     = 1'b1;
                occupancy_o = 2'd1;
            end
            ST_SKID: begin
                valid_o     = 1'b1;
                ready_o     = 1'b0;
                occupancy_o = 2'd2;
            end
            default: begin
                valid_o     = 1'b0;
                ready_o     = 1'b1;
                occupancy_o = 2'd0;
            end
        endcase
    end

    assign pc_incr_o      = main_q.pc_incr;
    assign reg_rd_data1_o = main_q.rd_data1;
    assign reg_rd_data2_o = main_q.rd_data2;
    assign reg_wr_port_o  = main_q.wr_port;
    assign ctrl_q2_o      = main_q.ctrl;
    assign instr_o        = main_q.instr;

endmodule

// File: tb/tb_q2q3_skid.sv
// Bench for q2q3_skid: directed scenarios plus a long random run, with a
// FIFO queue of expected bundles that is checked on every output transfer.
module tb_q2q3_skid;

    localparam int          CW  = 16;
    localparam int          PW  = 32 * 4 + 5 + CW;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk;
    logic          rst;
    logic          valid_i;
    logic          ready_o;
    logic [31:0]   pc_incr_i;
    logic [31:0]   reg_rd_data1_i;
    logic [31:0]   reg_rd_data2_i;
    logic [4:0]    reg_wr_port_i;
    logic [CW-1:0] ctrl_q2_i;
    logic [31:0]   instr_i;
    logic          flush_i;
    logic          valid_o;
    logic          ready_i;
    logic [31:0]   pc_incr_o;
    logic [31:0]   reg_rd_data1_o;
    logic [31:0]   reg_rd_data2_o;
    logic [4:0]    reg_wr_port_o;
    logic [CW-1:0] ctrl_q2_o;
    logic [31:0]   instr_o;
    logic [1:0]    occupancy_o;

    logic [PW-1:0] exp_q[$];
    int            errors;
    int            checks;

    q2q3_skid #(.CTRL_WIDTH(CW), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .pc_incr_i      (pc_incr_i),
        .reg_rd_data1_i (reg_rd_data1_i),
        .reg_rd_data2_i (reg_rd_data2_i),
        .reg_wr_port_i  (reg_wr_port_i),
        .ctrl_q2_i      (ctrl_q2_i),
        .instr_i        (instr_i),
        .flush_i        (flush_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .pc_incr_o      (pc_incr_o),
        .reg_rd_data1_o (reg_rd_data1_o),
        .reg_rd_data2_o (reg_rd_data2_o),
        .reg_wr_port_o  (reg_wr_port_o),
        .ctrl_q2_o      (ctrl_q2_o),
        .instr_o        (instr_o),
        .occupancy_o    (occupancy_o)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [PW-1:0] in_payload();
        return {pc_incr_i, reg_rd_data1_i, reg_rd_data2_i, reg_wr_port_i, ctrl_q2_i, instr_i};
    endfunction

    function automatic logic [PW-1:0] out_payload();
        return {pc_incr_o, reg_rd_data1_o, reg_rd_data2_o, reg_wr_port_o, ctrl_q2_o, instr_o};
    endfunction

    function automatic logic [PW-1:0] bubble_payload();
        logic [PW-1:0] b;
        b        = '0;
        b[31:0]  = NOP;
        return b;
    endfunction

    // Driver: set an input bundle derived from a tag, with random side fields.
    task automatic drive_bundle(input logic v, input logic [31:0] instr);
        valid_i        = v;
        instr_i        = instr;
        pc_incr_i      = $urandom;
        reg_rd_data1_i = $urandom;
        reg_rd_data2_i = $urandom;
        reg_wr_port_i  = 5'($urandom_range(0, 31));
        ctrl_q2_i      = CW'($urandom_range(0, 65535));
    endtask

    // One clock: scoreboard update from the handshake, edge, then checks on
    // the falling edge against the queue-based model.
    task automatic tick();
        logic [PW-1:0] exp;
        logic [PW-1:0] held;
        logic          stall;
        stall = 1'b0;
        held  = '0;
        if (!rst) begin
            if (valid_o && ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_transfer_unexpected: got instr=%h, required no bundle", instr_o);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_payload() !== exp) begin
                        errors++;
                        $display("FAIL out_payload: got %h required %h", out_payload(), exp);
                    end
                end
            end
            if (!flush_i && valid_i && ready_o) exp_q.push_back(in_payload());
            if (!flush_i && valid_o && !ready_i) begin
                stall = 1'b1;
                held  = out_payload();
            end
        end
        if (rst || flush_i) exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (occupancy_o !== 2'(exp_q.size())) begin
            errors++;
            $display("FAIL occupancy: got %0d required %0d", occupancy_o, exp_q.size());
        end
        checks++;
        if (valid_o !== (exp_q.size() > 0) || ready_o !== (exp_q.size() < 2)) begin
            errors++;
            $display("FAIL handshake: got valid_o=%b ready_o=%b required %b %b",
                     valid_o, ready_o, exp_q.size() > 0, exp_q.size() < 2);
        end
        if (exp_q.size() == 0) begin
            checks++;
            if (out_payload() !== bubble_payload()) begin
                errors++;
                $display("FAIL bubble: got %h required %h", out_payload(), bubble_payload());
            end
        end
        if (stall) begin
            checks++;
            if (out_payload() !== held) begin
                errors++;
                $display("FAIL stall_stable: got %h required %h", out_payload(), held);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
        drive_bundle(1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || instr_o !== NOP || ctrl_q2_o !== '0 || occupancy_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle: got v=%b r=%b instr=%h ctrl=%h occ=%0d required 0 1 %h 0 0",
                     valid_o, ready_o, instr_o, ctrl_q2_o, occupancy_o, NOP);
        end
    endtask

    task automatic test_streaming();
        ready_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            drive_bundle(1'b1, 32'(k));
            tick();
            checks++;
            if (instr_o !== 32'(k) || valid_o !== 1'b1 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: got instr=%h v=%b r=%b required %h 1 1", k, instr_o, valid_o, ready_o, k);
            end
        end
        drive_bundle(1'b0, 32'h0);
        tick();
        tick();
    endtask

    // Leaves the DUT in SKID holding A=0x100 in main and B=0x200 in skid.
    task automatic fill_skid();
        ready_i = 1'b0;
        drive_bundle(1'b1, 32'h100);
        tick();
        drive_bundle(1'b1, 32'h200);
        tick();
        checks++;
        if (occupancy_o !== 2'd2 || ready_o !== 1'b0 || instr_o !== 32'h100) begin
            errors++;
            $display("FAIL skid_fill: got occ=%0d r=%b instr=%h required 2 0 00000100", occupancy_o, ready_o, instr_o);
        end
    endtask

    task automatic test_backpressure();
        fill_skid();
        drive_bundle(1'b1, 32'h300);  // ignored: ready_o is 0
        tick();
        checks++;
        if (instr_o !== 32'h100) begin
            errors++;
            $display("FAIL bp_hold: got instr=%h required 00000100", instr_o);
        end
        drive_bundle(1'b0, 32'h0);
        ready_i = 1'b1;
        tick();
        checks++;
        if (instr_o !== 32'h200 || occupancy_o !== 2'd1) begin
            errors++;
            $display("FAIL bp_drain1: got instr=%h occ=%0d required 00000200 1", instr_o, occupancy_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
            errors++;
            $display("FAIL bp_drain2: got v=%b occ=%0d required 0 0", valid_o, occupancy_o);
        end
    endtask

    task automatic test_flush_skid();
        fill_skid();
        drive_bundle(1'b1, 32'hDEAD);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || occupancy_o !== 2'd0 || instr_o !== NOP || ctrl_q2_o !== '0) begin
            errors++;
            $display("FAIL flush_skid: got v=%b occ=%0d instr=%h ctrl=%h required 0 0 %h 0",
                     valid_o, occupancy_o, instr_o, ctrl_q2_o, NOP);
        end
        drive_bundle(1'b0, 32'h0);
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_reset_midstream();
        fill_skid();
        ready_i = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || occupancy_o !== 2'd0 || instr_o !== NOP) begin
            errors++;
            $display("FAIL reset_mid: got v=%b r=%b occ=%0d instr=%h required 0 1 0 %h",
                     valid_o, ready_o, occupancy_o, instr_o, NOP);
        end
        drive_bundle(1'b0, 32'h0);
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            drive_bundle($urandom_range(0, 3) != 0, 32'h1000 + 32'(i));
            ready_i = ($urandom_range(0, 2) != 0);
            flush_i = ($urandom_range(0, 199) == 0);
            tick();
        end
        flush_i = 1'b0;
        drive_bundle(1'b0, 32'h0);
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d bundles left, required 0", exp_q.size());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_skid();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
